// File: rtl/midi_mem_pkg.sv
// Shared types and constants for the CPU/MIDI memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package midi_mem_pkg;

  // Access issued by the arbiter in the current cycle.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_MIDI = 2'd2
  } arb_state_t;

  // MIDI note word layout: [15:8] velocity, [7] ignored, [6:0] pitch.
  localparam int NOTE_W    = 16;
  localparam int VEL_MSB   = 15;
  localparam int VEL_LSB   = 8;
  localparam int PITCH_MSB = 6;

  // Default first slot address of the pitch-class table.
  localparam logic [13:0] NOTE_BASE_DEFAULT = 14'h3F00;

endpackage

// File: rtl/midi_note_fifo.sv
// Synchronous FIFO holding queued MIDI note words.
// Latency: a pushed entry is visible on dout the cycle after the push.
// Backpressure: push is ignored while full, pop is ignored while empty.
module midi_note_fifo
  import midi_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = NOTE_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come straight from the registered occupancy count.
  assign full    = (level == (PTR_W + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (PTR_W + 1)'(1);
        2'b01:   level <= level - (PTR_W + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: an empty FIFO never exposes stale words.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/midi_mem_arbiter.sv
// Arbitrates CPU accesses and queued MIDI note writes onto one memory port.
// Latency: 1 cycle from sampled cpu_req / non-empty queue to the memory access.
// Backpressure: midi_ready = !full; CPU waits for cpu_gnt; optional MIDI_NOTE_OFF_FILTER_EN.
module midi_mem_arbiter
  import midi_mem_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 14,
  parameter int                FIFO_DEPTH = 4,
  parameter int                NUM_NOTES  = 12,
  parameter logic [ADDR_W-1:0] NOTE_BASE  = ADDR_W'(NOTE_BASE_DEFAULT),
  parameter int                STARVE_MAX = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  output logic                          cpu_gnt,
  input  logic                          midi_valid,
  input  logic [NOTE_W-1:0]             midi_note,
  output logic                          midi_ready,
  input  logic                          overflow_clr,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [NUM_NOTES-1:0]          note_hit,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int          SLOT_W    = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam int          CNT_W     = $clog2(STARVE_MAX + 1);
  localparam logic [7:0]  NOTES_DIV = 8'(NUM_NOTES);

  arb_state_t               state;
  logic [CNT_W-1:0]         starve_cnt;
  logic                     starved;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [NOTE_W-1:0]        fifo_dout;
  logic                     note_keep;
  logic                     push_req;
  logic                     drop_evt;
  logic                     cpu_win;
  logic                     midi_win;
  logic [7:0]               pitch_ext;
  logic [SLOT_W-1:0]        slot;
  logic [ADDR_W-1:0]        note_addr;
  logic [NUM_NOTES-1:0]     hit_vec;

`ifdef MIDI_NOTE_OFF_FILTER_EN
  // Note-off (velocity 0) is accepted on the handshake but never queued.
  assign note_keep = (midi_note[VEL_MSB:VEL_LSB] != 8'd0);
`else
  assign note_keep = 1'b1;
`endif

  assign midi_ready = !fifo_full;
  assign push_req   = midi_valid && !fifo_full && note_keep;
  assign drop_evt   = midi_valid && fifo_full;
  assign starved    = (starve_cnt == CNT_W'(STARVE_MAX));

  midi_note_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NOTE_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (midi_note),
    .pop   (midi_win),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level),
    .dout  (fifo_dout)
  );

  // CPU wins unless a queued note has already waited STARVE_MAX CPU wins.
  always_comb begin
    cpu_win  = cpu_req && !(!fifo_empty && starved);
    midi_win = !cpu_win && !fifo_empty;
  end

  // Map the queue head onto its pitch-class slot address and hit bit.
  always_comb begin
    pitch_ext = {1'b0, fifo_dout[PITCH_MSB:0]};
    slot      = SLOT_W'(pitch_ext % NOTES_DIV);
    note_addr = NOTE_BASE + ADDR_W'(slot);
    hit_vec   = NUM_NOTES'(1) << slot;
  end

  // The state names the access issued this cycle; enable and grant decode from it.
  assign cpu_gnt = (state == ARB_CPU);
  assign mem_en  = (state != ARB_IDLE);

  // Arbitration FSM with registered memory-side outputs and starvation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      note_hit   <= '0;
      starve_cnt <= '0;
    end else begin
      if (cpu_win) begin
        state     <= ARB_CPU;
        mem_we    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        note_hit  <= '0;
      end else if (midi_win) begin
        state     <= ARB_MIDI;
        mem_we    <= 1'b1;
        mem_addr  <= note_addr;
        mem_wdata <= DATA_W'(fifo_dout);
        note_hit  <= hit_vec;
      end else begin
        // Address and data deliberately hold their last values when idle.
        state     <= ARB_IDLE;
        mem_we    <= 1'b0;
        note_hit  <= '0;
      end

      if (fifo_empty || midi_win) begin
        starve_cnt <= '0;
      end else if (cpu_win && !starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  // Sticky drop flag; a new drop in the same cycle beats the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop_evt) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule
